arbitro_mux2x1_rr: RTL

Round-robin arbiter that shares the 2:1 multiplexer datapath between two requesters. It samples two request lines and drives the mux select and one-hot grants from a registered state machine. It returns the selected requester's data on a registered output with a valid flag. The block sits in front of any consumer fed by a shared `mux2x1_mfd` path.

---
 rtl/arb_pkg.sv | 31 +++
 rtl/arbitro_mux2x1_rr_mux.sv | 28 ++
 rtl/mux2x1_mfd.sv | 18 +
 rtl/arbitro_mux2x1_rr.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin 2:1 arbiter (arbitro_mux2x1_rr).
//   arb_state_t : arbiter FSM states
//   GNT_*       : one-hot grant encodings
//   HOLD_SAT    : saturation value of the consecutive-grant counter
//   gnt_of()    : grant vector decoded from a state
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_0    = 2'b01;
    localparam logic [1:0] GNT_1    = 2'b10;

    localparam logic [7:0] HOLD_SAT = 8'd255;

    function automatic logic [1:0] gnt_of(input arb_state_t s);
        case (s)
            GNT0:    gnt_of = GNT_0;
            GNT1:    gnt_of = GNT_1;
            default: gnt_of = GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/arbitro_mux2x1_rr_mux.sv
// -----------------------------------------------------------------------------
// arbitro_mux2x1_rr_mux
// WIDTH-bit 2:1 datapath built from one mux2x1_mfd per bit. Purely
// combinational; the output register lives in the arbiter top.
//   d0_i  : requester 0 data
//   d1_i  : requester 1 data
//   sel_i : 0 selects d0_i, 1 selects d1_i
//   y_o   : selected data
// -----------------------------------------------------------------------------
module arbitro_mux2x1_rr_mux #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] y_o
);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        mux2x1_mfd u_mux (
            .i0 (d0_i[b]),
            .i1 (d1_i[b]),
            .S  (sel_i),
            .Y  (y_o[b])
        );
    end

endmodule

// File: rtl/mux2x1_mfd.sv
// -----------------------------------------------------------------------------
// mux2x1_mfd
// 1-bit 2:1 multiplexer.
//   i0 : selected when S = 0
//   i1 : selected when S = 1
//   S  : select
//   Y  : output
// -----------------------------------------------------------------------------
module mux2x1_mfd (
    input  logic i0,
    input  logic i1,
    input  logic S,
    output logic Y
);

    assign Y = S ? i1 : i0;

endmodule

// File: rtl/arbitro_mux2x1_rr.sv
// -----------------------------------------------------------------------------
// arbitro_mux2x1_rr
// Round-robin arbiter sharing a 2:1 mux datapath between two requesters.
// A registered FSM drives one-hot grants and the mux select; the selected
// data is returned on a registered output with a valid flag.
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   req     : request lines, req[0] requester 0, req[1] requester 1
//   d0, d1  : requester data
//   gnt     : registered one-hot grant (never 2'b11)
//   sel     : registered mux select (held while IDLE)
//   y       : registered mux output, mux taken with the current registered sel
//   y_valid : y came from a granted source that was still requesting
//
// Handshake: a requester raises req[i] and holds it until gnt[i] is seen;
// the grant stays while req[i] stays high. Dropping req[i] releases the
// grant on the next edge. A request that drops before being granted is lost.
//
// Configuration macro: ARB_TIMEOUT_EN
//   defined   : a holder is forced to hand over after MAX_HOLD consecutive
//               grant cycles if the other requester is waiting.
//   undefined : the holder keeps the grant until it drops its request.
// -----------------------------------------------------------------------------
module arbitro_mux2x1_rr
    import arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [1:0]       gnt,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..255");
    end

    arb_state_t       state_q, state_d;
    logic             last_q;
    logic [1:0]       gnt_q;
    logic             sel_q;
    logic [WIDTH-1:0] y_q;
    logic             y_valid_q;
    logic [WIDTH-1:0] mux_y;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt_q;
    logic       expired;

    assign expired = (hold_cnt_q == HOLD_LIMIT);
`else
    logic       expired;

    assign expired = 1'b0;
`endif

    // Next-state: ties from IDLE go to the requester not served last;
    // a release hands straight over to a waiting requester.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                case (req)
                    2'b01:   state_d = GNT0;
                    2'b10:   state_d = GNT1;
                    2'b11:   state_d = last_q ? GNT0 : GNT1;
                    default: state_d = IDLE;
                endcase
            end
            GNT0: begin
                if (req[0] && !(req[1] && expired)) state_d = GNT0;
                else if (req[1])                    state_d = GNT1;
                else                                state_d = IDLE;
            end
            GNT1: begin
                if (req[1] && !(req[0] && expired)) state_d = GNT1;
                else if (req[0])                    state_d = GNT0;
                else                                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    arbitro_mux2x1_rr_mux #(.WIDTH(WIDTH)) u_dp (
        .d0_i  (d0),
        .d1_i  (d1),
        .sel_i (sel_q),
        .y_o   (mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt_q     <= GNT_NONE;
            sel_q     <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_of(state_d);
            // Datapath uses the grant/select that were active this cycle.
            y_q       <= mux_y;
            y_valid_q <= |(gnt_q & req);
            if (state_d == GNT0) begin
                sel_q  <= 1'b0;
                last_q <= 1'b0;
            end else if (state_d == GNT1) begin
                sel_q  <= 1'b1;
                last_q <= 1'b1;
            end
`ifdef ARB_TIMEOUT_EN
            if (state_d != IDLE && state_d == state_q) begin
                if (hold_cnt_q != HOLD_SAT) hold_cnt_q <= hold_cnt_q + 8'd1;
            end else begin
                hold_cnt_q <= '0;
            end
`endif
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule
